// File: rtl/psum_pkg.sv
// Shared defaults and elaboration helpers for the psum output path.
// Lane i of a packed psum row occupies bits [lane(i) +: PSUM_BW].
package psum_pkg;

    localparam int PSUM_BW = 16;
    localparam int COL     = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int lane(input int i, input int bw = PSUM_BW);
        return i * bw;
    endfunction

endpackage

// File: rtl/fifo_lane.sv
// One column's psum FIFO: depth words with wrap-bit pointers.
// A push is refused when full, judged on the state before any same-cycle pop.
module fifo_lane
    import psum_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [psum_bw-1:0] din,
    input  logic               push,
    input  logic               pop,
    output logic [psum_bw-1:0] dout,
    output logic               empty,
    output logic               full
);

    localparam int AW = clog2(depth);

    logic [psum_bw-1:0] r_mem [depth];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic               w_push_ok;
    logic               w_pop_ok;

    // Equal pointers mean empty; pointers differing only in the wrap bit mean full.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: storage has no reset; a slot is only read after it has been written,
    // and leaving it out of reset keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/ofifo_collect.sv
// Collects skewed per-column psums from the array's bottom row and releases
// them as aligned full rows once every column lane holds a word.
module ofifo_collect
    import psum_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*psum_bw-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_ovf,
    output logic                   o_udf
);

    logic [col-1:0]         w_empty;
    logic [col-1:0]         w_full;
    logic [col*psum_bw-1:0] w_head;
    logic                   w_pop;
    logic [col*psum_bw-1:0] r_out;
    logic                   r_ovf;
    logic                   r_udf;

    assign o_valid = ~|w_empty;
    assign o_full  = |w_full;
    assign o_ready = ~o_full;
    assign w_pop   = rd && o_valid;
    assign out     = r_out;
    assign o_ovf   = r_ovf;
    assign o_udf   = r_udf;

    for (genvar i = 0; i < col; i++) begin : g_lane
        fifo_lane #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .din   (in[lane(i, psum_bw) +: psum_bw]),
            .push  (wr[i]),
            .pop   (w_pop),
            .dout  (w_head[lane(i, psum_bw) +: psum_bw]),
            .empty (w_empty[i]),
            .full  (w_full[i])
        );
    end

    // Error flags are sticky until reset so a consumer can poll them lazily.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_pop)           r_out <= w_head;
            if (|(wr & w_full))  r_ovf <= 1'b1;
            if (rd && !o_valid)  r_udf <= 1'b1;
        end
    end

endmodule
